// File: rtl/axis_bram_readout.sv
// Streams a window of the capture BRAM out as AXI-Stream with tlast.
// Reads are credit-gated against a small skid FIFO so tready may stall freely.
module axis_bram_readout #(
    parameter int BRAM_ADDR_WIDTH = 16,
    parameter int BRAM_DATA_WIDTH = 16,
    parameter int READ_LATENCY    = 2,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic                       rd_start,
    input  logic [BRAM_ADDR_WIDTH-1:0] rd_start_addr,
    input  logic [BRAM_ADDR_WIDTH:0]   rd_length,
    output logic [31:0]                rd_status,
    output logic [BRAM_DATA_WIDTH-1:0] m_axis_tdata,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic                       m_axis_tlast,
    output logic                       bram_portb_clk,
    output logic [BRAM_ADDR_WIDTH-1:0] bram_portb_addr,
    input  logic [BRAM_DATA_WIDTH-1:0] bram_portb_rddata,
    output logic                       bram_portb_en
);
    localparam int AW = BRAM_ADDR_WIDTH;
    localparam int DW = BRAM_DATA_WIDTH;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int LW = $clog2(READ_LATENCY + 1);
    localparam int SW = CW + 1;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
    state_t state, state_nx;

    logic                    start_q;
    logic                    start_edge;
    logic [AW-1:0]           rd_addr;
    logic [AW:0]             remaining;
    logic [15:0]             beats;
    logic                    done_q;
    logic                    busy_q;
    logic [READ_LATENCY-1:0] pipe_v;
    logic [READ_LATENCY-1:0] pipe_l;
    logic [DW-1:0]           mem_d [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]   mem_l;
    logic [PW-1:0]           wr_ptr;
    logic [PW-1:0]           rd_ptr;
    logic [CW-1:0]           fcnt;
    logic [LW-1:0]           inflight;
    logic [SW-1:0]           used;
    logic                    issue;
    logic                    last_rd;
    logic                    abort;
    logic                    push;
    logic                    pop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        inflight = '0;
        for (int i = 0; i < READ_LATENCY; i++)
            inflight = inflight + LW'(pipe_v[i]);
    end

    // Occupancy before this cycle's pop: conservative but never overflows.
    assign used       = SW'(inflight) + SW'(fcnt);
    assign start_edge = rd_start & ~start_q;
    assign abort      = (state == READ || state == DRAIN) && !rd_start;
    assign issue      = (state == READ) && rd_start && (remaining != '0)
                        && (used < SW'(FIFO_DEPTH));
    assign last_rd    = (remaining == (AW + 1)'(1));
    assign push       = pipe_v[READ_LATENCY-1] && !abort;
    assign pop        = (fcnt != '0) && m_axis_tready;

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start_edge)
                    state_nx = (rd_length == '0) ? DONE : READ;
            end
            READ: begin
                if (abort)
                    state_nx = IDLE;
                else if (issue && last_rd)
                    state_nx = DRAIN;
            end
            DRAIN: begin
                if (abort)
                    state_nx = IDLE;
                else if (pop && mem_l[rd_ptr])
                    state_nx = DONE;
            end
            DONE: begin
                if (!rd_start)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state     <= IDLE;
            start_q   <= 1'b1;
            rd_addr   <= '0;
            remaining <= '0;
            beats     <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            pipe_v    <= '0;
            pipe_l    <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fcnt      <= '0;
            mem_l     <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem_d[i] <= '0;
        end else begin
            state   <= state_nx;
            start_q <= rd_start;
            done_q  <= (state == DONE);
            busy_q  <= (state == READ) || (state == DRAIN);

            if (state == IDLE && start_edge) begin
                rd_addr   <= rd_start_addr;
                remaining <= rd_length;
                beats     <= '0;
            end else begin
                if (issue) begin
                    rd_addr   <= rd_addr + AW'(1);
                    remaining <= remaining - (AW + 1)'(1);
                end
                if (pop && beats != 16'hFFFF)
                    beats <= beats + 16'd1;
            end

            pipe_v[0] <= issue;
            pipe_l[0] <= issue && last_rd;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_v[i] <= pipe_v[i-1] && !abort;
                pipe_l[i] <= pipe_l[i-1];
            end

            if (abort) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                fcnt   <= '0;
            end else begin
                if (push) begin
                    mem_d[wr_ptr] <= bram_portb_rddata;
                    mem_l[wr_ptr] <= pipe_l[READ_LATENCY-1];
                    wr_ptr        <= bump(wr_ptr);
                end
                if (pop)
                    rd_ptr <= bump(rd_ptr);
                unique case ({push, pop})
                    2'b10:   fcnt <= fcnt + CW'(1);
                    2'b01:   fcnt <= fcnt - CW'(1);
                    default: ;
                endcase
            end
        end
    end

    assign m_axis_tvalid   = (fcnt != '0);
    assign m_axis_tdata    = mem_d[rd_ptr];
    assign m_axis_tlast    = (fcnt != '0) && mem_l[rd_ptr];
    assign rd_status       = {beats, 14'd0, busy_q, done_q};
    assign bram_portb_clk  = aclk;
    assign bram_portb_addr = rd_addr;
    assign bram_portb_en   = issue;

endmodule

// File: tb/tb_axis_bram_readout.sv
// Directed bench for axis_bram_readout with a beat scoreboard.
// BRAM model returns data equal to the address after two cycles.
module tb_axis_bram_readout;
    localparam int FD = 4;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        rd_start;
    logic [15:0] rd_start_addr;
    logic [16:0] rd_length;
    logic [31:0] rd_status;
    logic [15:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic        bram_portb_clk;
    logic [15:0] bram_portb_addr;
    logic [15:0] bram_portb_rddata;
    logic        bram_portb_en;

    axis_bram_readout dut (
        .aclk              (aclk),
        .aresetn           (aresetn),
        .rd_start          (rd_start),
        .rd_start_addr     (rd_start_addr),
        .rd_length         (rd_length),
        .rd_status         (rd_status),
        .m_axis_tdata      (m_axis_tdata),
        .m_axis_tvalid     (m_axis_tvalid),
        .m_axis_tready     (m_axis_tready),
        .m_axis_tlast      (m_axis_tlast),
        .bram_portb_clk    (bram_portb_clk),
        .bram_portb_addr   (bram_portb_addr),
        .bram_portb_rddata (bram_portb_rddata),
        .bram_portb_en     (bram_portb_en)
    );

    always #5 aclk = ~aclk;

    logic [15:0] bq1, bq2;
    always @(posedge bram_portb_clk) begin
        if (bram_portb_en) bq1 <= bram_portb_addr;
        bq2 <= bq1;
    end
    assign bram_portb_rddata = bq2;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int t0    = 0;
    int os    = 0;
    bit rnd_ready  = 0;
    bit stall_prev = 0;
    logic [16:0] prev_beat;
    logic [16:0] sb [$];
    logic [63:0] en_tr, val_tr, last_tr, done_tr;
    logic [15:0] addr_tr [64];
    logic [15:0] data_tr [64];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_axis"}, {14'd0, m_axis_tvalid, m_axis_tlast, m_axis_tdata}, 0);
        chk({tag, "_bram"}, {15'd0, bram_portb_en, bram_portb_addr}, 0);
        chk({tag, "_status"}, rd_status, 0);
    endtask

    task automatic monitor();
        int r;
        logic xfer;
        logic [16:0] e;
        if (!aresetn) begin
            stall_prev = 0;
            return;
        end
        r = cyc - t0;
        if (r >= 0 && r < 64) begin
            en_tr[r]   = bram_portb_en;
            val_tr[r]  = m_axis_tvalid;
            last_tr[r] = m_axis_tlast;
            done_tr[r] = rd_status[0];
            addr_tr[r] = bram_portb_addr;
            data_tr[r] = m_axis_tdata;
        end
        if (stall_prev) begin
            chk("stall_valid", {31'd0, m_axis_tvalid}, 1);
            chk("stall_beat", {15'd0, m_axis_tlast, m_axis_tdata}, {15'd0, prev_beat});
        end
        xfer = m_axis_tvalid && m_axis_tready;
        if (bram_portb_en)
            chk("credit", {31'd0, os + 1 <= FD}, 1);
        if (xfer) begin
            if (sb.size() == 0) begin
                chk("sb_extra", sb.size(), 1);
            end else begin
                e = sb.pop_front();
                chk("beat", {15'd0, m_axis_tlast, m_axis_tdata}, {15'd0, e});
            end
            os--;
        end
        if (bram_portb_en) os++;
        stall_prev = m_axis_tvalid && !m_axis_tready;
        prev_beat  = {m_axis_tlast, m_axis_tdata};
    endtask

    task automatic tick();
        @(negedge aclk);
        monitor();
        @(posedge aclk);
        #1;
        cyc++;
        if (rnd_ready) m_axis_tready = 1'($urandom_range(0, 1));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clr_trace();
        t0 = cyc;
        en_tr = '0; val_tr = '0; last_tr = '0; done_tr = '0;
    endtask

    task automatic launch(input logic [15:0] a, input int len);
        logic [15:0] d;
        clr_trace();
        rd_start_addr = a;
        rd_length     = 17'(len);
        rd_start      = 1'b1;
        for (int i = 0; i < len; i++) begin
            d = a + 16'(i);
            sb.push_back({i == len - 1, d});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        aresetn = 1'b0; rd_start = 1'b1; m_axis_tready = 1'b1;
        rd_start_addr = '0; rd_length = '0;
        ticks(3);
        chk_reset("por");
        aresetn = 1'b1;
        clr_trace();
        ticks(6);
        chk("hold_en", {26'd0, en_tr[5:0]}, 0);
        chk("hold_valid", {26'd0, val_tr[5:0]}, 0);
        chk("hold_status", rd_status, 0);
        rd_start = 1'b0;
        ticks(2);

        launch(16'h0010, 8);
        ticks(20);
        chk("t1_en", {12'd0, en_tr[19:0]}, 32'h001FE);
        chk("t1_valid", {12'd0, val_tr[19:0]}, 32'h00FF0);
        chk("t1_last", {12'd0, last_tr[19:0]}, 32'h00800);
        chk("t1_done", {12'd0, done_tr[19:0]}, 32'hFE000);
        for (int r = 1; r <= 8; r++)
            chk("t1_addr", {16'd0, addr_tr[r]}, 32'h10 + r - 1);
        for (int r = 4; r <= 11; r++)
            chk("t1_data", {16'd0, data_tr[r]}, 32'h10 + r - 4);
        chk("t1_sb", sb.size(), 0);
        chk("t1_status", rd_status, 32'h0008_0001);
        rd_start = 1'b0;
        ticks(3);
        chk("t1_idle", rd_status, 32'h0008_0000);

        launch(16'hFFFE, 4);
        ticks(14);
        chk("t2_en", {27'd0, en_tr[4:0]}, 32'h1E);
        chk("t2_wrap_addr", {16'd0, addr_tr[3]}, 0);
        chk("t2_sb", sb.size(), 0);
        chk("t2_status", rd_status, 32'h0004_0001);
        rd_start = 1'b0;
        ticks(3);

        rnd_ready = 1;
        launch(16'h1234, 16);
        for (int i = 0; i < 400 && rd_status[0] == 1'b0; i++) tick();
        rnd_ready = 0;
        m_axis_tready = 1'b1;
        chk("t3_done", {31'd0, rd_status[0]}, 1);
        chk("t3_sb", sb.size(), 0);
        chk("t3_count", {16'd0, rd_status[31:16]}, 16);
        rd_start = 1'b0;
        ticks(3);

        launch(16'h0055, 0);
        ticks(6);
        chk("t4_en", {26'd0, en_tr[5:0]}, 0);
        chk("t4_valid", {26'd0, val_tr[5:0]}, 0);
        chk("t4_done", {26'd0, done_tr[5:0]}, 32'h3C);
        rd_start = 1'b0;
        ticks(3);
        chk("t4_idle", rd_status, 0);

        launch(16'h0200, 100);
        ticks(20);
        rd_start = 1'b0;
        tick();
        sb.delete();
        os = 0;
        stall_prev = 0;
        ticks(10);
        chk("t5_en_on", {13'd0, en_tr[19:1]}, 32'h7FFFF);
        chk("t5_en_off", {22'd0, en_tr[30:21]}, 0);
        chk("t5_valid_off", {22'd0, val_tr[30:21]}, 0);
        chk("t5_no_last", {1'b0, last_tr[30:0]}, 0);
        chk("t5_status", rd_status, 32'h0011_0000);
        launch(16'h0300, 3);
        ticks(12);
        chk("t5_restart_addr", {16'd0, addr_tr[1]}, 32'h0300);
        chk("t5_restart_sb", sb.size(), 0);
        chk("t5_restart_status", rd_status, 32'h0003_0001);
        rd_start = 1'b0;
        ticks(3);

        m_axis_tready = 1'b0;
        launch(16'h0040, 3);
        ticks(10);
        chk("t6_stalled", {31'd0, m_axis_tvalid}, 1);
        chk("t6_busy", {30'd0, rd_status[1:0]}, 2);
        aresetn = 1'b0;
        tick();
        chk_reset("t6");
        sb.delete();
        os = 0;
        tick();
        aresetn = 1'b1;
        clr_trace();
        ticks(6);
        chk("t6_no_relaunch_en", {26'd0, en_tr[5:0]}, 0);
        chk("t6_no_relaunch_valid", {26'd0, val_tr[5:0]}, 0);
        chk("t6_status", rd_status, 0);
        rd_start = 1'b0;
        m_axis_tready = 1'b1;
        ticks(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
